// File: rtl/hazard_ctrl_if.sv
// Pipeline-control bundle between the hazard controller and the pipeline registers.
// Optional HAZARD_PERF_EN adds the stall/flush performance counter outputs.
interface hazard_ctrl_if #(
    parameter int unsigned REG_ADDR_WIDTH = 5
);
    logic [REG_ADDR_WIDTH-1:0] rs1d;
    logic [REG_ADDR_WIDTH-1:0] rs2d;
    logic [REG_ADDR_WIDTH-1:0] rs1e;
    logic [REG_ADDR_WIDTH-1:0] rs2e;
    logic [REG_ADDR_WIDTH-1:0] rde;
    logic [REG_ADDR_WIDTH-1:0] rdm;
    logic [REG_ADDR_WIDTH-1:0] rdw;
    logic                      regwritem;
    logic                      regwritew;
    logic                      resultsrce0;
    logic                      pcsrce;
    logic                      imem_ready;
    logic                      stallf;
    logic                      stalld;
    logic                      flushd;
    logic                      flushe;
    logic [1:0]                forwardae;
    logic [1:0]                forwardbe;
    logic                      imem_err;
`ifdef HAZARD_PERF_EN
    logic [31:0]               stall_cnt;
    logic [31:0]               flush_cnt;
`endif

    // Pipeline side: supplies register fields and status, consumes controls.
    modport master (
        output rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw,
        output regwritem, regwritew, resultsrce0, pcsrce, imem_ready,
        input  stallf, stalld, flushd, flushe, forwardae, forwardbe, imem_err
`ifdef HAZARD_PERF_EN
        , input stall_cnt, flush_cnt
`endif
    );

    // Controller side.
    modport slave (
        input  rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw,
        input  regwritem, regwritew, resultsrce0, pcsrce, imem_ready,
        output stallf, stalld, flushd, flushe, forwardae, forwardbe, imem_err
`ifdef HAZARD_PERF_EN
        , output stall_cnt, flush_cnt
`endif
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: stall/flush, operand forwarding, imem wait watchdog.
// Define HAZARD_PERF_EN to add saturating stall/flush cycle counters.
module hazard_ctrl #(
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave hz
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [REG_ADDR_WIDTH-1:0] X0 = '0;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        RUN       = 2'b00,
        IMEM_WAIT = 2'b01
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             err_q;
    logic             in_wait_c;
    logic             fetch_stall_c;
    logic             lwstall_c;

    // Exit cycle (IMEM_WAIT with imem_ready=1) follows RUN rules, so only a low ready stalls fetch.
    assign in_wait_c     = (state_q == IMEM_WAIT) && !hz.imem_ready;
    assign fetch_stall_c = in_wait_c || !hz.imem_ready;

    assign lwstall_c = hz.resultsrce0 && (hz.rde != X0) &&
                       ((hz.rde == hz.rs1d) || (hz.rde == hz.rs2d));

    assign cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    // Operand forwarding; memory stage has priority over writeback.
    always_comb begin
        hz.forwardae = 2'b00;
        hz.forwardbe = 2'b00;
        if (!rst) begin
            if (hz.regwritem && (hz.rdm != X0) && (hz.rdm == hz.rs1e)) begin
                hz.forwardae = 2'b10;
            end else if (hz.regwritew && (hz.rdw != X0) && (hz.rdw == hz.rs1e)) begin
                hz.forwardae = 2'b01;
            end
            if (hz.regwritem && (hz.rdm != X0) && (hz.rdm == hz.rs2e)) begin
                hz.forwardbe = 2'b10;
            end else if (hz.regwritew && (hz.rdw != X0) && (hz.rdw == hz.rs2e)) begin
                hz.forwardbe = 2'b01;
            end
        end
    end

    // Stall/flush priority: reset, redirect, fetch wait, load-use.
    always_comb begin
        hz.stallf = 1'b0;
        hz.stalld = 1'b0;
        hz.flushd = 1'b0;
        hz.flushe = 1'b0;
        if (rst) begin
            hz.flushd = 1'b1;
            hz.flushe = 1'b1;
        end else if (hz.pcsrce) begin
            hz.flushd = 1'b1;
            hz.flushe = 1'b1;
        end else if (fetch_stall_c) begin
            hz.stallf = 1'b1;
            hz.stalld = 1'b1;
            hz.flushe = 1'b1;
        end else if (lwstall_c) begin
            hz.stallf = 1'b1;
            hz.stalld = 1'b1;
            hz.flushe = 1'b1;
        end
    end

    // Fetch sequencing FSM with watchdog counter and sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    cnt_q <= '0;
                    if (!hz.imem_ready) state_q <= IMEM_WAIT;
                end
                IMEM_WAIT: begin
                    if (hz.imem_ready) begin
                        state_q <= RUN;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_d;
                        if (cnt_d == CNT_MAX) err_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= RUN;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign hz.imem_err = err_q;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    // Saturating cycle counters for stalled decode and execute bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (hz.stalld && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (hz.flushe && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (TIMEOUT_CYCLES=4); checks HAZARD_PERF_EN counters when defined.
module tb_hazard_ctrl;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    hazard_ctrl_if #(.REG_ADDR_WIDTH(5)) hz ();

    hazard_ctrl #(
        .REG_ADDR_WIDTH(5),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hz (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {stallf, stalld, flushd, flushe}
    function automatic logic [31:0] ctl();
        return 32'({hz.stallf, hz.stalld, hz.flushd, hz.flushe});
    endfunction

    task automatic idle();
        hz.rs1d = '0; hz.rs2d = '0; hz.rs1e = '0; hz.rs2e = '0;
        hz.rde = '0; hz.rdm = '0; hz.rdw = '0;
        hz.regwritem = 1'b0; hz.regwritew = 1'b0;
        hz.resultsrce0 = 1'b0; hz.pcsrce = 1'b0; hz.imem_ready = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        idle();

        @(negedge clk);
        check("rst_ctl", ctl(), 32'b0011);
        check("rst_fa", 32'(hz.forwardae), 32'd0);
        check("rst_err", 32'(hz.imem_err), 32'd0);

        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("idle_ctl", ctl(), 32'b0000);

        // Load-use: one bubble, then clear.
        next_cycle();
        hz.resultsrce0 = 1'b1; hz.rde = 5'd5; hz.rs1d = 5'd5;
        @(negedge clk);
        check("lw_ctl", ctl(), 32'b1101);
        next_cycle();
        hz.resultsrce0 = 1'b0; hz.rde = 5'd0;
        @(negedge clk);
        check("lw_after", ctl(), 32'b0000);

        // rs2d match also stalls; x0 never does.
        next_cycle();
        hz.resultsrce0 = 1'b1; hz.rde = 5'd9; hz.rs1d = 5'd1; hz.rs2d = 5'd9;
        @(negedge clk);
        check("lw_rs2", ctl(), 32'b1101);
        next_cycle();
        hz.rde = 5'd0; hz.rs1d = 5'd0; hz.rs2d = 5'd0;
        @(negedge clk);
        check("lw_x0", ctl(), 32'b0000);

        // Forwarding.
        next_cycle();
        idle();
        hz.rdm = 5'd7; hz.rdw = 5'd7; hz.regwritem = 1'b1; hz.regwritew = 1'b1;
        hz.rs1e = 5'd7; hz.rs2e = 5'd0;
        @(negedge clk);
        check("fwd_a_mem", 32'(hz.forwardae), 32'd2);
        check("fwd_b_x0", 32'(hz.forwardbe), 32'd0);
        next_cycle();
        hz.rdm = 5'd0;
        @(negedge clk);
        check("fwd_a_wb", 32'(hz.forwardae), 32'd1);
        next_cycle();
        hz.rdm = 5'd3; hz.rs2e = 5'd3; hz.regwritew = 1'b0;
        @(negedge clk);
        check("fwd_a_none", 32'(hz.forwardae), 32'd0);
        check("fwd_b_mem", 32'(hz.forwardbe), 32'd2);
        next_cycle();
        hz.regwritem = 1'b0;
        @(negedge clk);
        check("fwd_b_nowe", 32'(hz.forwardbe), 32'd0);

        // Redirect beats load-use.
        next_cycle();
        idle();
        hz.resultsrce0 = 1'b1; hz.rde = 5'd5; hz.rs1d = 5'd5; hz.pcsrce = 1'b1;
        @(negedge clk);
        check("br_lw", ctl(), 32'b0011);

        // Three-cycle imem wait.
        next_cycle();
        idle();
        for (int i = 0; i < 3; i++) begin
            hz.imem_ready = 1'b0;
            @(negedge clk);
            check($sformatf("wait%0d", i), ctl(), 32'b1101);
            next_cycle();
        end
        hz.imem_ready = 1'b1;
        @(negedge clk);
        check("wait_exit", ctl(), 32'b0000);
        check("wait_err", 32'(hz.imem_err), 32'd0);

        // Redirect while fetch is waiting.
        next_cycle();
        hz.imem_ready = 1'b0; hz.pcsrce = 1'b1;
        @(negedge clk);
        check("br_wait", ctl(), 32'b0011);
        next_cycle();
        hz.pcsrce = 1'b0;
        @(negedge clk);
        check("br_wait2", ctl(), 32'b1101);
        next_cycle();
        hz.imem_ready = 1'b1;
        next_cycle();

        // Watchdog: L0 is the RUN cycle, L1..L4 the IMEM_WAIT cycles.
        hz.imem_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("wd_pre%0d", k), 32'(hz.imem_err), 32'd0);
            next_cycle();
        end
        @(negedge clk);
        check("wd_set", 32'(hz.imem_err), 32'd1);
        check("wd_ctl", ctl(), 32'b1101);
        next_cycle();
        hz.imem_ready = 1'b1;
        @(negedge clk);
        check("wd_run_ctl", ctl(), 32'b0000);
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("wd_sticky", 32'(hz.imem_err), 32'd1);

        // Asynchronous reset in the middle of a wait.
        next_cycle();
        hz.imem_ready = 1'b0;
        next_cycle();
        #1;
        rst = 1'b1;
        #1;
        check("arst_ctl", ctl(), 32'b0011);
        check("arst_err", 32'(hz.imem_err), 32'd0);
`ifdef HAZARD_PERF_EN
        check("arst_stall_cnt", hz.stall_cnt, 32'd0);
        check("arst_flush_cnt", hz.flush_cnt, 32'd0);
`endif
        next_cycle();
        rst = 1'b0;
        hz.imem_ready = 1'b1;
        @(negedge clk);
        check("post_rst_ctl", ctl(), 32'b0000);
        check("post_rst_err", 32'(hz.imem_err), 32'd0);

`ifdef HAZARD_PERF_EN
        // Two stall cycles and one redirect: stall_cnt=2, flush_cnt=3.
        next_cycle();
        hz.imem_ready = 1'b0;
        next_cycle();
        next_cycle();
        hz.imem_ready = 1'b1; hz.pcsrce = 1'b1;
        next_cycle();
        hz.pcsrce = 1'b0;
        @(negedge clk);
        check("perf_stall", hz.stall_cnt, 32'd2);
        check("perf_flush", hz.flush_cnt, 32'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
